// File: rtl/fifo_rd_drain.sv
// Read-side adapter: drains a 1-cycle-latency FIFO read port into a valid/ready
// stream through a small prefetch buffer, and counts delivered words.
module fifo_rd_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fifo_empty,
  output logic                             fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]            fifo_rdata,
  input  logic                             flush,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   buf_level,
  output logic [CNT_WIDTH-1:0]             rd_count
);

  localparam int LW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [LW-1:0]         occ_q, occ_d;
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic                  pend_q;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];

  logic                  arrive;
  logic                  pop;
  logic [LW:0]           fill;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // The issue decision counts the in-flight word as occupied so an arrival
  // always has a free slot; m_ready is deliberately absent from this path.
  always_comb begin
    fill       = {1'b0, occ_q} + {{LW{1'b0}}, pend_q};
    fifo_rd_en = !rst && !flush && !fifo_empty && (fill < (LW+1)'(BUF_DEPTH));
    m_valid    = (occ_q != '0);
    pop        = m_valid && m_ready;
    arrive     = pend_q && !flush;
    m_data     = m_valid ? buf_q[head_q] : '0;
    head_d     = pop    ? ptr_inc(head_q) : head_q;
    tail_d     = arrive ? ptr_inc(tail_q) : tail_q;
    occ_d      = occ_q + {{(LW-1){1'b0}}, arrive} - {{(LW-1){1'b0}}, pop};
    cnt_d      = pop ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      pend_q <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
      pend_q <= fifo_rd_en;
    end
    // Flush leaves the delivered-word count alone; a pop in the flush cycle counts.
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    if (!rst && arrive) buf_q[tail_q] <= fifo_rdata;
  end

  assign buf_level = occ_q;
  assign rd_count  = cnt_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    arrive |-> (occ_q != LW'(BUF_DEPTH)));

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: a queue-based model of the buffer and FIFO order,
// plus a second small instance (depth 2, 4-bit counter) for order and wrap.
module tb_fifo_rd_drain;

  localparam int DW    = 8;
  localparam int DEPTH = 3;
  localparam int CW    = 16;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst, flush, fifo_empty, fifo_rd_en, m_valid, m_ready;
  logic [DW-1:0] fifo_rdata, m_data;
  logic [LW-1:0] buf_level;
  logic [CW-1:0] rd_count;

  logic          rst2, fifo_empty2, fifo_rd_en2, m_valid2;
  logic          flush2   = 1'b0;
  logic          m_ready2 = 1'b1;
  logic [DW-1:0] fifo_rdata2, m_data2;
  logic [1:0]    buf_level2;
  logic [3:0]    rd_count2;

  fifo_rd_drain #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rdata(fifo_rdata), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .buf_level(buf_level), .rd_count(rd_count));

  fifo_rd_drain #(.DATA_WIDTH(DW), .BUF_DEPTH(2), .CNT_WIDTH(4)) dut2 (
    .clk(clk), .rst(rst2), .fifo_empty(fifo_empty2), .fifo_rd_en(fifo_rd_en2),
    .fifo_rdata(fifo_rdata2), .flush(flush2), .m_valid(m_valid2), .m_ready(m_ready2),
    .m_data(m_data2), .buf_level(buf_level2), .rd_count(rd_count2));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] src[$];
  logic [DW-1:0] bufq[$];
  logic [DW-1:0] src2[$];
  logic [DW-1:0] exp2[$];
  bit            infl, prev_rd, prev_rd2;
  int            cnt, acc, acc2, rd_issued, xfer_n;
  bit            last_hs, hs_seen;
  logic [DW-1:0] hs_data;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit fl, input bit rdy, input bit stall);
    bit exp_rd, exp_pop;
    @(negedge clk);
    if (prev_rd && src.size() > 0) fifo_rdata = src.pop_front();
    else fifo_rdata = 8'($urandom);
    if (prev_rd2 && src2.size() > 0) fifo_rdata2 = src2.pop_front();
    else fifo_rdata2 = 8'($urandom);
    rst         = r;
    flush       = fl;
    m_ready     = rdy;
    fifo_empty  = stall || (src.size() == 0);
    fifo_empty2 = (src2.size() == 0);
    #1;
    exp_rd = !r && !fl && !fifo_empty && ((bufq.size() + int'(infl)) < DEPTH);
    check_val("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
    check_val("m_valid", 32'(m_valid), 32'(bufq.size() != 0));
    if (bufq.size() != 0) check_val("m_data", 32'(m_data), 32'(bufq[0]));
    check_val("buf_level", 32'(buf_level), 32'(bufq.size()));
    check_val("rd_count", 32'(rd_count), 32'(cnt % 65536));
    if (infl && !fl && !r) check_val("arrive_room", 32'(int'(buf_level) < DEPTH), 32'd1);
    last_hs = m_valid && m_ready;
    if (last_hs) begin
      $display("xfer n=%0d data=%02h rd_count=%0d", xfer_n, m_data, rd_count);
      xfer_n++;
      acc++;
      if (!hs_seen) begin
        hs_seen = 1'b1;
        hs_data = m_data;
      end
    end
    if (fifo_rd_en) rd_issued++;
    exp_pop = (bufq.size() != 0) && rdy;
    if (r) begin
      bufq.delete();
      infl = 1'b0;
      cnt  = 0;
    end else begin
      if (exp_pop) begin
        bufq.delete(0);
        cnt++;
      end
      if (fl) begin
        bufq.delete();
        infl = 1'b0;
      end else begin
        if (infl) bufq.push_back(fifo_rdata);
        infl = exp_rd;
      end
    end
    prev_rd = fifo_rd_en;
    // Second instance: strict FIFO order and a 4-bit wrapping count.
    check_val("rd_count2", 32'(rd_count2), 32'(acc2 % 16));
    check_val("level2_le2", 32'(buf_level2 <= 2'd2), 32'd1);
    if (m_valid2) begin
      if (exp2.size() == 0) check_val("extra2", 32'(m_valid2), 32'd0);
      else begin
        check_val("m_data2", 32'(m_data2), 32'(exp2[0]));
        exp2.delete(0);
        acc2++;
      end
    end
    prev_rd2 = fifo_rd_en2;
  endtask

  initial begin
    logic [DW-1:0] w[10];
    int            win, cnt_b;
    rst = 1'b1; rst2 = 1'b1; flush = 1'b0; m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_empty2 = 1'b1; fifo_rdata = '0; fifo_rdata2 = '0;
    infl = 0; prev_rd = 0; prev_rd2 = 0; cnt = 0; acc = 0; acc2 = 0;
    rd_issued = 0; xfer_n = 0; hs_seen = 0; hs_data = '0; last_hs = 0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_valid", 32'(m_valid), 32'd0);
    check_val("rst_data", 32'(m_data), 32'd0);
    check_val("rst_level", 32'(buf_level), 32'd0);
    check_val("rst_count", 32'(rd_count), 32'd0);
    check_val("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check_val("rst_valid2", 32'(m_valid2), 32'd0);
    rst2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      logic [DW-1:0] v;
      v = 8'($urandom);
      src2.push_back(v);
      exp2.push_back(v);
    end

    // Three known words, consumer always ready.
    src.push_back(8'hA1); src.push_back(8'hB2); src.push_back(8'hC3);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    check_val("A_count", 32'(rd_count), 32'd3);
    check_val("A_level", 32'(buf_level), 32'd0);

    // 64 random words at full rate after the 2-cycle fill.
    acc = 0; win = 0;
    for (int i = 0; i < 64; i++) src.push_back(8'($urandom));
    for (int i = 0; i < 70; i++) begin
      step(0, 0, 1, 0);
      if (i >= 2 && i < 66 && last_hs) win++;
    end
    check_val("B_window", 32'(win), 32'd64);
    check_val("B_acc", 32'(acc), 32'd64);
    check_val("B_count", 32'(rd_count), 32'd67);

    // Backpressure: buffer fills to 3 and the head word freezes.
    for (int i = 0; i < 10; i++) begin
      w[i] = 8'($urandom);
      src.push_back(w[i]);
    end
    rd_issued = 0;
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    check_val("C_reads", 32'(rd_issued), 32'd3);
    check_val("C_level", 32'(buf_level), 32'd3);
    check_val("C_head", 32'(m_data), 32'(w[0]));
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0);
    check_val("C_count", 32'(rd_count), 32'd77);

    // Flush with two buffered words and one in flight.
    for (int i = 0; i < 6; i++) begin
      w[i] = 8'($urandom);
      src.push_back(w[i]);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    cnt_b = int'(rd_count);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check_val("D_level", 32'(buf_level), 32'd0);
    check_val("D_valid", 32'(m_valid), 32'd0);
    check_val("D_count", 32'(rd_count), 32'(cnt_b));
    hs_seen = 0;
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
    check_val("D_next", 32'(hs_data), 32'(w[3]));
    check_val("D_count2", 32'(rd_count), 32'(cnt_b + 3));

    // Reset mid-stream with two buffered words and one in flight.
    for (int i = 0; i < 6; i++) begin
      w[i] = 8'($urandom);
      src.push_back(w[i]);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    check_val("F_valid", 32'(m_valid), 32'd0);
    check_val("F_data", 32'(m_data), 32'd0);
    check_val("F_level", 32'(buf_level), 32'd0);
    check_val("F_count", 32'(rd_count), 32'd0);
    hs_seen = 0;
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
    check_val("F_next", 32'(hs_data), 32'(w[3]));
    check_val("F_count2", 32'(rd_count), 32'd3);

    // Random traffic: pushes, stalls, backpressure, occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) != 0 && src.size() < 16) src.push_back(8'($urandom));
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 7) == 0));
    end
    for (int i = 0; i < 30; i++) step(0, 0, 1, 0);
    check_val("E_drained", 32'(buf_level), 32'd0);

    check_val("W_acc2", 32'(acc2), 32'd20);
    check_val("W_wrap2", 32'(rd_count2), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
